tt_proj_mux_ctrl: RTL and testbench

//  Parametrised successor to the single-project slot wrapper. Hosts N_PROJ project slots on one

---
 rtl/tt_mux_pkg.sv | 31 +++
 rtl/tt_rst_hold_cnt.sv | 31 +++
 rtl/tt_proj_mux_ctrl.sv | 154 +++++++++++++++
 tb/tb_tt_proj_mux_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_mux_pkg.sv
// Shared definitions for the multi-project slot mux controller: FSM state
// encoding, packed pin-bus field offsets and sequencing constants.
package tt_mux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_SWITCH_OFF = 2'd1,
        ST_HOLD       = 2'd2,
        ST_ACTIVE     = 2'd3
    } state_t;

    // Input bus packing: {uio_in, ui_in, rst_n, clk}
    localparam int IW_CLK     = 0;
    localparam int IW_RSTN    = 1;
    localparam int IW_UI_LSB  = 2;
    localparam int IW_UI_MSB  = 9;
    localparam int IW_UIO_LSB = 10;
    localparam int IW_UIO_MSB = 17;

    // Output bus packing: {uio_oe, uio_out, uo_out}
    localparam int OW_UO_LSB  = 0;
    localparam int OW_UO_MSB  = 7;
    localparam int OW_UIO_LSB = 8;
    localparam int OW_UIO_MSB = 15;
    localparam int OW_OE_LSB  = 16;
    localparam int OW_OE_MSB  = 23;

    // Cycles spent with every slot disconnected before the new one is touched
    localparam int SWITCH_OFF_CYC = 2;

endpackage

// File: rtl/tt_rst_hold_cnt.sv
// Down-counter that times how long the newly selected project is held in
// user reset. Loading sets it to RST_HOLD-1 so that done rises on the last
// hold cycle; it stops at zero and never wraps.
module tt_rst_hold_cnt #(
    parameter int RST_HOLD = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic dec,
    output logic done
);

    localparam int CNT_W = $clog2(RST_HOLD + 1);

    logic [CNT_W-1:0] cnt;

    // Load on entry to HOLD, then count down to zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_W'(RST_HOLD - 1);
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/tt_proj_mux_ctrl.sv
// Multi-project slot mux controller. Routes one shared packed pin bus to one
// of N_PROJ project slots and sequences every selection change as
// disconnect -> hold new project in user reset -> go live.
// Optional build macro TT_MUX_SWITCH_CNT_EN adds an 8-bit saturating count of
// accepted selection requests on port switch_cnt.
module tt_proj_mux_ctrl
    import tt_mux_pkg::*;
#(
    parameter int N_PROJ   = 4,
    parameter int IW_W     = 18,
    parameter int OW_W     = 24,
    parameter int RST_HOLD = 8,
    parameter int SEL_W    = $clog2(N_PROJ) + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [SEL_W-1:0]         sel_in,
    input  logic                     sel_valid,
    output logic                     sel_ready,
    input  logic [IW_W-1:0]          iw_in,
    output logic [N_PROJ*IW_W-1:0]   iw_out,
    output logic [N_PROJ-1:0]        ena_out,
    input  logic [N_PROJ*OW_W-1:0]   ow_in,
    output logic [OW_W-1:0]          ow_out,
    output logic                     busy
`ifdef TT_MUX_SWITCH_CNT_EN
    ,
    output logic [7:0]               switch_cnt
`endif
);

    localparam int SW_W = $clog2(SWITCH_OFF_CYC);
    localparam logic [SEL_W-1:0] SEL_NONE = SEL_W'(N_PROJ);

    state_t           state;
    logic [SEL_W-1:0] nxt_sel;
    logic [SEL_W-1:0] cur_sel;
    logic [SW_W-1:0]  sw_cnt;
    logic             accept;
    logic             sw_last;
    logic             nxt_valid;
    logic             hold_load;
    logic             hold_done;
    logic [IW_W-1:0]  iw_hold;
    logic [OW_W-1:0]  ow_sel;

    assign sel_ready = (state == ST_IDLE) || (state == ST_ACTIVE);
    assign busy      = (state == ST_SWITCH_OFF) || (state == ST_HOLD);
    assign accept    = sel_valid && sel_ready;
    assign sw_last   = (sw_cnt == SW_W'(SWITCH_OFF_CYC - 1));
    assign nxt_valid = (nxt_sel < SEL_NONE);
    assign hold_load = (state == ST_SWITCH_OFF) && sw_last && nxt_valid;

    tt_rst_hold_cnt #(
        .RST_HOLD (RST_HOLD)
    ) u_hold_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (hold_load),
        .dec   (state == ST_HOLD),
        .done  (hold_done)
    );

    // Selection sequencer: accept, disconnect, hold in reset, go live
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            nxt_sel <= SEL_NONE;
            cur_sel <= SEL_NONE;
            sw_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_ACTIVE: begin
                    if (accept) begin
                        nxt_sel <= sel_in;
                        sw_cnt  <= '0;
                        state   <= ST_SWITCH_OFF;
                    end
                end
                ST_SWITCH_OFF: begin
                    if (sw_last) begin
                        if (nxt_valid) begin
                            state <= ST_HOLD;
                        end else begin
                            cur_sel <= nxt_sel;
                            state   <= ST_IDLE;
                        end
                    end else begin
                        sw_cnt <= sw_cnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (hold_done) begin
                        cur_sel <= nxt_sel;
                        state   <= ST_ACTIVE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Pin bus as seen by a project in HOLD: user rst_n forced low
    always_comb begin
        iw_hold          = iw_in;
        iw_hold[IW_RSTN] = 1'b0;
    end

    // Per-slot enable and input routing; unselected slots stay at zero
    always_comb begin
        ena_out = '0;
        iw_out  = '0;
        for (int k = 0; k < N_PROJ; k++) begin
            if ((state == ST_HOLD) && (nxt_sel == SEL_W'(k))) begin
                ena_out[k]                = 1'b1;
                iw_out[k*IW_W +: IW_W]    = iw_hold;
            end else if ((state == ST_ACTIVE) && (cur_sel == SEL_W'(k))) begin
                ena_out[k]                = 1'b1;
                iw_out[k*IW_W +: IW_W]    = iw_in;
            end
        end
    end

    // Select the live project's output bus
    always_comb begin
        ow_sel = '0;
        for (int k = 0; k < N_PROJ; k++) begin
            if (cur_sel == SEL_W'(k)) begin
                ow_sel = ow_in[k*OW_W +: OW_W];
            end
        end
    end

    // Registered pin output; quiet whenever no project is live
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ow_out <= '0;
        end else begin
            ow_out <= (state == ST_ACTIVE) ? ow_sel : '0;
        end
    end

`ifdef TT_MUX_SWITCH_CNT_EN
    // Saturating count of accepted selection requests
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            switch_cnt <= '0;
        end else if (accept && (switch_cnt != 8'hFF)) begin
            switch_cnt <= switch_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tt_proj_mux_ctrl.sv
// Self-checking bench for tt_proj_mux_ctrl. A timeline model derives the
// expected slot mode from the cycle distance to the last accepted request.
module tb_tt_proj_mux_ctrl;

    localparam int N_PROJ   = 4;
    localparam int IW_W     = 18;
    localparam int OW_W     = 24;
    localparam int RST_HOLD = 8;
    localparam int SEL_W    = $clog2(N_PROJ) + 1;

    localparam int M_IDLE = 0;
    localparam int M_OFF  = 1;
    localparam int M_HOLD = 2;
    localparam int M_ACT  = 3;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [SEL_W-1:0]       sel_in;
    logic                   sel_valid;
    logic                   sel_ready;
    logic [IW_W-1:0]        iw_in;
    logic [N_PROJ*IW_W-1:0] iw_out;
    logic [N_PROJ-1:0]      ena_out;
    logic [N_PROJ*OW_W-1:0] ow_in;
    logic [OW_W-1:0]        ow_out;
    logic                   busy;
`ifdef TT_MUX_SWITCH_CNT_EN
    logic [7:0]             switch_cnt;
`endif

    tt_proj_mux_ctrl #(
        .N_PROJ   (N_PROJ),
        .IW_W     (IW_W),
        .OW_W     (OW_W),
        .RST_HOLD (RST_HOLD),
        .SEL_W    (SEL_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sel_in     (sel_in),
        .sel_valid  (sel_valid),
        .sel_ready  (sel_ready),
        .iw_in      (iw_in),
        .iw_out     (iw_out),
        .ena_out    (ena_out),
        .ow_in      (ow_in),
        .ow_out     (ow_out),
        .busy       (busy)
`ifdef TT_MUX_SWITCH_CNT_EN
        ,
        .switch_cnt (switch_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    int             cyc     = 0;
    bit             in_seq  = 0;
    int             acc_cyc = 0;
    int             tgt     = 0;
    int             live    = -1;
    int             exp_cnt = 0;
    logic [OW_W-1:0] exp_ow = '0;

    task automatic step(input logic rv, input logic [SEL_W-1:0] rs, input logic rr);
        int m;
        int d;
        logic [N_PROJ-1:0]      exp_ena;
        logic [N_PROJ*IW_W-1:0] exp_iw;
        logic                   exp_rdy;
        logic                   exp_busy;
        @(negedge clk);
        rst_n     = rr;
        sel_valid = rv;
        sel_in    = rs;
        iw_in     = IW_W'($urandom) | IW_W'(2);
        ow_in     = {$urandom, $urandom, $urandom};
        #1;
        if (!rr) begin
            in_seq  = 0;
            live    = -1;
            exp_ow  = '0;
            exp_cnt = 0;
        end
        m = -1;
        if (in_seq) begin
            d = cyc - acc_cyc;
            if (d <= 2) begin
                m = M_OFF;
            end else if (tgt >= N_PROJ) begin
                in_seq = 0;
                live   = -1;
            end else if (d < 3 + RST_HOLD) begin
                m = M_HOLD;
            end else begin
                in_seq = 0;
                live   = tgt;
            end
        end
        if (m < 0) m = (live >= 0) ? M_ACT : M_IDLE;

        exp_ena = '0;
        exp_iw  = '0;
        if (m == M_HOLD) begin
            exp_ena[tgt]                = 1'b1;
            exp_iw[tgt*IW_W +: IW_W]    = iw_in & ~IW_W'(2);
        end else if (m == M_ACT) begin
            exp_ena[live]               = 1'b1;
            exp_iw[live*IW_W +: IW_W]   = iw_in;
        end
        exp_rdy  = (m == M_IDLE) || (m == M_ACT);
        exp_busy = !exp_rdy;

        n_assert++;
        assert (ena_out === exp_ena) else begin
            n_fail++;
            $error("FAIL ena_out cyc=%0d got=%b exp=%b", cyc, ena_out, exp_ena);
        end
        n_assert++;
        assert (iw_out === exp_iw) else begin
            n_fail++;
            $error("FAIL iw_out cyc=%0d got=%h exp=%h", cyc, iw_out, exp_iw);
        end
        n_assert++;
        assert (sel_ready === exp_rdy) else begin
            n_fail++;
            $error("FAIL sel_ready cyc=%0d got=%b exp=%b", cyc, sel_ready, exp_rdy);
        end
        n_assert++;
        assert (busy === exp_busy) else begin
            n_fail++;
            $error("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy);
        end
        n_assert++;
        assert (ow_out === exp_ow) else begin
            n_fail++;
            $error("FAIL ow_out cyc=%0d got=%h exp=%h", cyc, ow_out, exp_ow);
        end
`ifdef TT_MUX_SWITCH_CNT_EN
        n_assert++;
        assert (switch_cnt === 8'(exp_cnt)) else begin
            n_fail++;
            $error("FAIL switch_cnt cyc=%0d got=%0d exp=%0d", cyc, switch_cnt, exp_cnt);
        end
`endif

        // Model advance for the coming clock edge
        exp_ow = (rr && (m == M_ACT)) ? ow_in[live*OW_W +: OW_W] : '0;
        if (rr && rv && exp_rdy) begin
            in_seq  = 1;
            acc_cyc = cyc;
            tgt     = int'(rs);
            if (exp_cnt < 255) exp_cnt++;
        end
        cyc++;
    endtask

    task automatic req(input int s);
        step(1'b1, SEL_W'(s), 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, SEL_W'($urandom_range(0, 7)), 1'b1);
    endtask

    initial begin
        rst_n     = 1'b0;
        sel_valid = 1'b0;
        sel_in    = '0;
        iw_in     = '0;
        ow_in     = '0;

        // Reset state
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);
        idle(2);

        // Select slot 2 from IDLE
        req(2);
        idle(13);

        // Switch from live slot 2 to slot 0
        req(0);
        idle(13);

        // Deselect: "none" goes back to IDLE
        req(7);
        idle(4);

        // Request during HOLD is ignored
        req(3);
        idle(4);
        step(1'b1, SEL_W'(1), 1'b1);
        step(1'b1, SEL_W'(1), 1'b1);
        idle(10);

        // Reselect the live slot: full re-reset sequence
        req(3);
        idle(13);

        // Select value equal to N_PROJ: treated as none
        req(4);
        idle(4);

        // Reset in the middle of a switch
        req(2);
        idle(4);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        idle(3);

        // Random requests
        for (int i = 0; i < 200; i++) begin
            step(($urandom_range(0, 3) == 0), SEL_W'($urandom_range(0, 7)), 1'b1);
        end

        // Many back-to-back requests (saturation of the optional counter)
        step(1'b0, '0, 1'b0);
        idle(1);
        for (int i = 0; i < 300; i++) begin
            req(7);
            idle(2);
        end
        idle(3);
`ifdef TT_MUX_SWITCH_CNT_EN
        n_assert++;
        assert (switch_cnt === 8'd255) else begin
            n_fail++;
            $error("FAIL switch_cnt_sat got=%0d exp=255", switch_cnt);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
